// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, {pc,instr} buffer.
// Define IF_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [31:0] pc_mem_q [FIFO_DEPTH];
  logic [31:0] ins_mem_q [FIFO_DEPTH];

  logic [CW:0] used;
  logic [31:0] tgt;
  logic fifo_empty, fifo_full;
  logic grant, keep, byp_vld;
  logic push, pop;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  assign tgt = {redirect_pc_i[31:2], 2'b00};

  // Credit covers both in-flight and buffered words so a response always fits.
  assign used = {1'b0, outst_q} + {1'b0, cnt_q};
  assign imem_req_o = !rst_i && (used < DEPTH_W);
  assign imem_addr_o = fetch_pc_q;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full = (cnt_q == DEPTH_C);
  assign grant = imem_req_o && imem_gnt_i;
  assign keep = imem_rvalid_i && (disc_q == '0) && !redirect_i;

`ifdef IF_BYPASS_EN
  assign byp_vld = fifo_empty && keep;
`else
  assign byp_vld = 1'b0;
`endif

  assign valid_o = (!fifo_empty || byp_vld) && !redirect_i;
  assign pop = valid_o && ready_i && !fifo_empty;
  assign push = keep && !(byp_vld && ready_i);

  always_comb begin
    instr_o = NOP;
    pc_o = 32'h0;
    if (valid_o) begin
      if (byp_vld) begin
        instr_o = imem_rdata_i;
        pc_o = resp_pc_q;
      end else begin
        instr_o = ins_mem_q[rptr_q];
        pc_o = pc_mem_q[rptr_q];
      end
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d = resp_pc_q;
    outst_d = outst_q + CW'(grant) - CW'(imem_rvalid_i);
    disc_d = disc_q;
    cnt_d = cnt_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    if (redirect_i) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_d = tgt;
      resp_pc_d = tgt;
      disc_d = outst_d;
      cnt_d = '0;
      rptr_d = '0;
      wptr_d = '0;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rvalid_i && disc_q != '0) disc_d = disc_q - CW'(1);
      if (keep) resp_pc_d = resp_pc_q + 32'd4;
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop) rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q <= '0;
      disc_q <= '0;
      cnt_q <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q <= outst_d;
      disc_q <= disc_d;
      cnt_q <= cnt_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wptr_q] <= resp_pc_q;
      ins_mem_q[wptr_q] <= imem_rdata_i;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i) !(push && fifo_full && !pop)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table, directed redirect/wrap/reset
// sequences, then randomized memory timing against an in-order stream model.
module tb_instr_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_1000;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic req, gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] addr, rdata = '0;
  logic [31:0] instr, pc;
  logic valid, ready = 1'b1;

  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_o(instr), .pc_o(pc), .valid_o(valid), .ready_i(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int due;
  } pend_t;

  typedef struct {
    bit rdy;
    bit v;
    logic [31:0] off;
    bit rq;
    logic [31:0] aoff;
  } vec_t;

  pend_t pend[$];
  vec_t tbl[22];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mode = 0;
  int n_cons = 0;
  logic [31:0] exp_pc = RPC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h00A0_0093 + (a >> 2) * 32'h0010_0080;
  endfunction

  function automatic int lat_f();
    if (mode == 0) return 0;
    if (mode == 1) return 4;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive_mem();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata = mem_word(pend[0].addr);
    end else begin
      rvalid = 1'b0;
      rdata = $urandom;
    end
    gnt = (mode == 2) ? (($urandom % 4) != 0) : 1'b1;
  endtask

  // Called at a falling edge: checks invariants, advances one cycle.
  task automatic step();
    logic c_req, c_gnt, c_rv, c_val, c_rdy, c_red;
    logic [31:0] c_addr, c_pc, c_ins, c_tgt;
    c_req = req; c_gnt = gnt; c_rv = rvalid; c_val = valid;
    c_rdy = ready; c_red = redirect; c_addr = addr; c_pc = pc;
    c_ins = instr; c_tgt = redirect_pc;
    chk("addr_align", {30'b0, c_addr[1:0]}, 32'h0);
    chk("credit", (pend.size() <= DEPTH) ? 32'h1 : 32'h0, 32'h1);
    if (c_red) chk("valid_in_redirect", {31'b0, c_val}, 32'h0);
    if (!c_val) begin
      chk("idle_instr", c_ins, NOP);
      chk("idle_pc", c_pc, 32'h0);
    end
    @(posedge clk);
    #1;
    if (c_val && c_rdy) begin
      chk("stream_pc", c_pc, exp_pc);
      chk("stream_instr", c_ins, mem_word(exp_pc));
      exp_pc += 32'd4;
      n_cons++;
    end
    if (c_red) exp_pc = c_tgt & 32'hFFFF_FFFC;
    if (c_rv && pend.size() > 0) void'(pend.pop_front());
    if (c_req && c_gnt) pend.push_back('{addr: c_addr, due: cyc + 1 + lat_f()});
    cyc++;
    drive_mem();
  endtask

  // Entered just after a rising edge; leaves 1 time unit after the edge
  // at which the design starts its first post-reset cycle.
  task automatic reset_dut(input bit check);
    #2;
    rst = 1'b1;
    rvalid = 1'b0;
    pend.delete();
    #1;
    if (check) begin
      chk("rst_valid", {31'b0, valid}, 32'h0);
      chk("rst_req", {31'b0, req}, 32'h0);
      chk("rst_addr", addr, RPC);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, NOP);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend.delete();
    exp_pc = RPC;
    cyc = 0;
    drive_mem();
  endtask

  task automatic wait_valid(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid) begin
        found = 1'b1;
        return;
      end
      step();
    end
    chk("wait_valid_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    bit f;
    // Single-cycle memory from reset, then decode stalls for 10 cycles.
    for (int i = 0; i < 22; i++) tbl[i] = '{1, 1, 16, 0, 24};
    tbl[0] = '{1, 0, 0, 1, 0};
    tbl[1] = '{1, 0, 0, 1, 4};
    tbl[2] = '{1, 1, 0, 0, 8};
    tbl[3] = '{1, 1, 4, 1, 8};
    tbl[4] = '{1, 0, 0, 1, 12};
    tbl[5] = '{1, 1, 8, 0, 16};
    tbl[6] = '{1, 1, 12, 1, 16};
    tbl[7] = '{1, 0, 0, 1, 20};
    for (int i = 8; i < 18; i++) tbl[i].rdy = 1'b0;
    tbl[19] = '{1, 1, 20, 1, 24};
    tbl[20] = '{1, 0, 0, 1, 28};
    tbl[21] = '{1, 1, 24, 0, 32};

    mode = 0;
    reset_dut(1'b0);
    for (int i = 0; i < 22; i++) begin
      logic [31:0] epc;
      ready = tbl[i].rdy;
      redirect = 1'b0;
      epc = tbl[i].v ? RPC + tbl[i].off : 32'h0;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].v});
      chk($sformatf("tbl%0d_pc", i), pc, epc);
      chk($sformatf("tbl%0d_instr", i), instr,
          tbl[i].v ? mem_word(epc) : NOP);
      chk($sformatf("tbl%0d_req", i), {31'b0, req}, {31'b0, tbl[i].rq});
      chk($sformatf("tbl%0d_addr", i), addr, RPC + tbl[i].aoff);
      step();
    end

    // Two slow requests in flight when the redirect lands.
    mode = 1;
    ready = 1'b1;
    reset_dut(1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      step();
    end
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    chk("redir1_inflight", 32'(pend.size()), 32'd2);
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("redir1_addr", addr, 32'h0000_0100);
    chk("redir1_req_held", {31'b0, req}, 32'h0);
    step();
    wait_valid(30, f);
    if (f) chk("redir1_first_pc", pc, 32'h0000_0100);
    step();

    // Misaligned target with a grant and a response in the redirect cycle.
    mode = 0;
    reset_dut(1'b0);
    @(negedge clk);
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    @(negedge clk);
    chk("redir2_rvalid_and_grant", {30'b0, rvalid, req & gnt}, 32'h3);
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("redir2_addr", addr, 32'h0000_0100);
    chk("redir2_req", {31'b0, req}, 32'h1);
    step();
    wait_valid(20, f);
    if (f) chk("redir2_first_pc", pc, 32'h0000_0100);
    step();

    // PC wrap at the top of the address space.
    reset_dut(1'b0);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    step();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] wpc;
      wpc = 32'hFFFF_FFF8 + 32'(4 * k);
      wait_valid(20, f);
      if (f) chk($sformatf("wrap_pc%0d", k), pc, wpc);
      step();
    end

    // Fill the buffer, then pulse reset between edges.
    reset_dut(1'b0);
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    chk("full_valid", {31'b0, valid}, 32'h1);
    chk("full_req", {31'b0, req}, 32'h0);
    step();
    reset_dut(1'b1);
    ready = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'b0, req}, 32'h1);
    chk("post_rst_addr", addr, RPC);
    step();
    wait_valid(10, f);
    if (f) chk("post_rst_pc", pc, RPC);
    step();

    // Random memory timing, stalls and redirects.
    mode = 2;
    n_cons = 0;
    reset_dut(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) reset_dut(1'b1);
      ready = ($urandom % 4) != 0;
      redirect = ($urandom % 32) == 0;
      redirect_pc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16))
                                           : ($urandom & 32'h0000_FFFF);
      @(negedge clk);
      step();
    end
    redirect = 1'b0;
    chk("rand_progress", (n_cons > 150) ? 32'h1 : 32'h0, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
